result_drain_streamer: RTL and testbench

Reads finished rows out of the result SRAM and streams them to the host as narrow valid/ready beats. It is the reader end of the result path: the systolic array's write counter fills the result SRAM, and this block drains it. While the block is draining, it asserts `valid_address` so the result write counter is frozen. It also serializes each MATRIX_SIZE×PARTIAL_SUM_BW row into OUT_BW-wide beats.

---
 rtl/tpu_pkg.sv | 33 +++
 rtl/result_drain_streamer_if.sv | 13 +
 rtl/drain_beat_serializer.sv | 61 ++++++
 rtl/result_drain_streamer.sv | 97 +++++++++
 tb/tb_result_drain_streamer.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU result path: drain FSM states, beat geometry
// helpers and an elaboration-time width check.
`ifndef TPU_CHECK_DIV
`define TPU_CHECK_DIV(num, den, blk) \
  if (((num) % (den)) != 0) begin : blk \
    $error("width check: %0d is not divisible by %0d", (num), (den)); \
  end
`endif

package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } drain_state_e;

  function automatic int calc_beats(int matrix_size, int psum_bw, int out_bw);
    return (matrix_size * psum_bw) / out_bw;
  endfunction

  function automatic int calc_epb(int out_bw, int psum_bw);
    return out_bw / psum_bw;
  endfunction

  // Counter width that stays legal when only one beat exists.
  function automatic int min1_clog2(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_drain_streamer_if.sv
// Valid/ready beat stream from the result drain to the host.
interface result_drain_streamer_if #(
  parameter int OUT_BW = 96
) ();
  logic [OUT_BW-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              m_frame_last;

  modport master (output m_data, m_valid, m_last, m_frame_last, input m_ready);
  modport slave  (input m_data, m_valid, m_last, m_frame_last, output m_ready);
endinterface

// File: rtl/drain_beat_serializer.sv
// Holds one result row and presents it as OUT_BW-wide beats, lowest element
// in the LSBs of the first beat.
module drain_beat_serializer
  import tpu_pkg::*;
#(
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 128,
  parameter int OUT_BW         = 96
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  load,
  input  logic                                  frame_last_row,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_data,
  result_drain_streamer_if.master               stream,
  output logic                                  row_done
);

  localparam int BEATS  = calc_beats(MATRIX_SIZE, PARTIAL_SUM_BW, OUT_BW);
  localparam int BEAT_W = min1_clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] row_buf;
  logic [BEAT_W-1:0]                     beat;
  logic                                  valid;
  logic                                  xfer;

  assign xfer = valid && stream.m_ready;

  // NOTE: the row buffer is deliberately not reset; it is only observable
  // while valid is high, and m_data is forced to zero otherwise.
  always_ff @(posedge clk) begin
    if (load) row_buf <= row_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= 1'b0;
      beat  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      beat  <= '0;
    end else if (xfer) begin
      if (beat == LAST_BEAT) begin
        valid <= 1'b0;
        beat  <= '0;
      end else begin
        beat <= beat + BEAT_W'(1);
      end
    end
  end

  assign stream.m_valid      = valid;
  assign stream.m_data       = valid ? row_buf[beat*OUT_BW +: OUT_BW] : '0;
  assign stream.m_last       = valid && (beat == LAST_BEAT);
  assign stream.m_frame_last = stream.m_last && frame_last_row;
  assign row_done            = xfer && (beat == LAST_BEAT);

endmodule

// File: rtl/result_drain_streamer.sv
// Drains finished rows from the result SRAM and streams them to the host,
// freezing the result write counter while busy.
module result_drain_streamer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE    = 10,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int MATRIX_SIZE    = 128,
  parameter int OUT_BW         = 96
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic [ADDRESSSIZE-1:0]                base_addr,
  input  logic [ADDRESSSIZE:0]                  drain_rows,
  output logic                                  valid_address,
  output logic [ADDRESSSIZE-1:0]                sram_result_address,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_result_data_out,
  result_drain_streamer_if.master               stream,
  output logic                                  busy,
  output logic                                  done
);

  localparam int ROW_W = ADDRESSSIZE + 1;

  `TPU_CHECK_DIV(MATRIX_SIZE*PARTIAL_SUM_BW, OUT_BW, g_row_div_check)
  `TPU_CHECK_DIV(OUT_BW, PARTIAL_SUM_BW, g_beat_div_check)

  drain_state_e           state, state_next;
  logic [ROW_W-1:0]       row_idx, rows_q, row_next;
  logic [ADDRESSSIZE-1:0] base_q;
  logic                   zero_done, last_row, row_done, accept, row_load;

  assign accept   = (state == IDLE) && start;
  assign row_next = row_idx + ROW_W'(1);
  assign last_row = (row_next == rows_q);
  assign row_load = (state == WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && (drain_rows != '0)) state_next = FETCH;
      FETCH:   state_next = WAIT;
      WAIT:    state_next = SEND;
      SEND:    if (row_done) state_next = last_row ? DONE : FETCH;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job parameters are latched once; later changes on the inputs are ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      zero_done           <= 1'b0;
      base_q              <= '0;
      rows_q              <= '0;
      row_idx             <= '0;
      sram_result_address <= '0;
    end else begin
      zero_done <= accept && (drain_rows == '0);
      if (accept && (drain_rows != '0)) begin
        base_q              <= base_addr;
        rows_q              <= drain_rows;
        row_idx             <= '0;
        sram_result_address <= base_addr;
      end else if ((state == SEND) && row_done && !last_row) begin
        row_idx             <= row_next;
        sram_result_address <= base_q + row_next[ADDRESSSIZE-1:0];
      end
    end
  end

  assign busy          = (state != IDLE);
  assign valid_address = busy;
  assign done          = (state == DONE) || zero_done;

  drain_beat_serializer #(
    .PARTIAL_SUM_BW(PARTIAL_SUM_BW),
    .MATRIX_SIZE   (MATRIX_SIZE),
    .OUT_BW        (OUT_BW)
  ) u_serializer (
    .clk           (clk),
    .rstn          (rstn),
    .load          (row_load),
    .frame_last_row(last_row),
    .row_data      (sram_result_data_out),
    .stream        (stream),
    .row_done      (row_done)
  );

endmodule

// File: tb/tb_result_drain_streamer.sv
// Self-checking bench for result_drain_streamer: table of drain jobs plus
// hand sequences for timing, reset and mid-drain reset; beats via scoreboard.
module tb_result_drain_streamer;

  localparam int AW    = 10;
  localparam int RW    = AW + 1;
  localparam int PSUM  = 24;
  localparam int MS    = 4;
  localparam int OBW   = 48;
  localparam int BEATS = 2;
  localparam int EPB   = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    logic [OBW-1:0] data;
    logic           last;
    logic           frame_last;
  } beat_t;

  typedef struct {
    int base;
    int rows;
    int mode;        // 0: ready high, 1: random ready, 2: pattern 1,0,0,1
    int inject;      // loop index at which a stray start is pulsed, -1 none
    int exp_cycles;  // start-to-done cycles, 0 when stalls make it variable
    int exp_beats;
  } job_t;

  logic                 clk;
  logic                 rstn;
  logic                 start;
  logic [AW-1:0]        base_addr;
  logic [RW-1:0]        drain_rows;
  logic                 valid_address;
  logic [AW-1:0]        sram_result_address;
  logic [PSUM*MS-1:0]   sram_result_data_out;
  logic                 busy;
  logic                 done;
  logic [PSUM*MS-1:0]   mem [DEPTH];

  result_drain_streamer_if #(.OUT_BW(OBW)) s_if ();

  result_drain_streamer #(
    .ADDRESSSIZE   (AW),
    .PARTIAL_SUM_BW(PSUM),
    .MATRIX_SIZE   (MS),
    .OUT_BW        (OBW)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .start               (start),
    .base_addr           (base_addr),
    .drain_rows          (drain_rows),
    .valid_address       (valid_address),
    .sram_result_address (sram_result_address),
    .sram_result_data_out(sram_result_data_out),
    .stream              (s_if),
    .busy                (busy),
    .done                (done)
  );

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    xfers  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read result SRAM: data one cycle after the address.
  always @(posedge clk) sram_result_data_out <= mem[sram_result_address];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

  function automatic logic [PSUM-1:0] elem(int a, int k);
    if (a == 5) return PSUM'(k + 1);
    return PSUM'(a * 256 + k * 16 + 7) ^ ((a % 2 == 1) ? 24'h800000 : 24'h000000);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_job(input int base, input int rows);
    beat_t e;
    int    a;
    for (int r = 0; r < rows; r++) begin
      a = (base + r) % DEPTH;
      for (int b = 0; b < BEATS; b++) begin
        e.data = '0;
        for (int i = 0; i < EPB; i++) e.data[i*PSUM +: PSUM] = elem(a, b * EPB + i);
        e.last       = (b == BEATS - 1);
        e.frame_last = e.last && (r == rows - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic pick_ready(input int mode, input int i);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 1) return 1'($urandom_range(0, 1));
    if (mode == 2) return pat[i % 4];
    return 1'b1;
  endfunction

  // Monitor: samples between edges, scores transfers and checks stall stability.
  initial begin
    beat_t e;
    beat_t prev;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev = '{default: '0};
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid_held", 64'(s_if.m_valid), 64'd1);
          check("stall_data_held", 64'(s_if.m_data), 64'(prev.data));
          check("stall_last_held", 64'(s_if.m_last), 64'(prev.last));
          check("stall_frame_last_held", 64'(s_if.m_frame_last), 64'(prev.frame_last));
        end
        if (s_if.m_valid && s_if.m_ready) begin
          xfers++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", s_if.m_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 64'(s_if.m_data), 64'(e.data));
            check("beat_last", 64'(s_if.m_last), 64'(e.last));
            check("beat_frame_last", 64'(s_if.m_frame_last), 64'(e.frame_last));
          end
        end
        prev_stall      = s_if.m_valid && !s_if.m_ready;
        prev.data       = s_if.m_data;
        prev.last       = s_if.m_last;
        prev.frame_last = s_if.m_frame_last;
      end
    end
  end

  task automatic run_job(input int idx, input job_t j);
    int cyc;
    int vbad;
    int x0;
    bit seen;
    cyc  = 0;
    vbad = 0;
    seen = 1'b0;
    x0   = xfers;
    @(negedge clk);
    base_addr     = AW'(j.base);
    drain_rows    = RW'(j.rows);
    start         = 1'b1;
    s_if.m_ready  = pick_ready(j.mode, 0);
    push_job(j.base, j.rows);
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done) seen = 1'b1;
      if (valid_address !== (j.rows != 0)) vbad++;
      @(negedge clk);
      if (i == j.inject) begin
        start      = 1'b1;
        base_addr  = AW'(99);
        drain_rows = RW'(3);
      end else begin
        start = 1'b0;
      end
      s_if.m_ready = pick_ready(j.mode, i + 1);
    end
    check($sformatf("job%0d_done_seen", idx), 64'(seen), 64'd1);
    if (j.exp_cycles != 0) check($sformatf("job%0d_cycles", idx), 64'(cyc), 64'(j.exp_cycles));
    check($sformatf("job%0d_beats", idx), 64'(xfers - x0), 64'(j.exp_beats));
    check($sformatf("job%0d_valid_address", idx), 64'(vbad), 64'd0);
    check($sformatf("job%0d_queue_empty", idx), 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
    check($sformatf("job%0d_idle_busy", idx), 64'(busy), 64'd0);
    check($sformatf("job%0d_idle_done", idx), 64'(done), 64'd0);
  endtask

  initial begin
    job_t jobs[7];
    int   dcount;

    for (int a = 0; a < DEPTH; a++)
      for (int k = 0; k < MS; k++) mem[a][k*PSUM +: PSUM] = elem(a, k);

    jobs[0] = '{base: 5,    rows: 1, mode: 0, inject: -1, exp_cycles: 5, exp_beats: 2};
    jobs[1] = '{base: 5,    rows: 1, mode: 2, inject: -1, exp_cycles: 0, exp_beats: 2};
    jobs[2] = '{base: 1023, rows: 2, mode: 0, inject: -1, exp_cycles: 9, exp_beats: 4};
    jobs[3] = '{base: 0,    rows: 0, mode: 0, inject: -1, exp_cycles: 1, exp_beats: 0};
    jobs[4] = '{base: 7,    rows: 2, mode: 0, inject: 2,  exp_cycles: 9, exp_beats: 4};
    jobs[5] = '{base: 100,  rows: 3, mode: 1, inject: -1, exp_cycles: 0, exp_beats: 6};
    jobs[6] = '{base: 1022, rows: 1, mode: 0, inject: -1, exp_cycles: 5, exp_beats: 2};

    rstn         = 1'b0;
    start        = 1'b0;
    base_addr    = '0;
    drain_rows   = '0;
    s_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(s_if.m_valid), 64'd0);
    check("rst_m_data", 64'(s_if.m_data), 64'd0);
    check("rst_m_last", 64'(s_if.m_last), 64'd0);
    check("rst_m_frame_last", 64'(s_if.m_frame_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid_address", 64'(valid_address), 64'd0);
    check("rst_sram_address", 64'(sram_result_address), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Cycle-exact single-row drain from address 5.
    @(negedge clk);
    base_addr    = AW'(5);
    drain_rows   = RW'(1);
    start        = 1'b1;
    s_if.m_ready = 1'b1;
    push_job(5, 1);
    @(posedge clk);
    #1;
    check("e0_busy", 64'(busy), 64'd1);
    check("e0_valid_address", 64'(valid_address), 64'd1);
    check("e0_sram_address", 64'(sram_result_address), 64'd5);
    check("e0_m_valid", 64'(s_if.m_valid), 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("e1_m_valid", 64'(s_if.m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("e2_m_valid", 64'(s_if.m_valid), 64'd1);
    check("e2_m_data", 64'(s_if.m_data), 64'h0000_0000_0200_0001);
    check("e2_m_last", 64'(s_if.m_last), 64'd0);
    @(posedge clk);
    #1;
    check("e3_m_data", 64'(s_if.m_data), 64'h0000_0000_0400_0003);
    check("e3_m_last", 64'(s_if.m_last), 64'd1);
    check("e3_m_frame_last", 64'(s_if.m_frame_last), 64'd1);
    check("e3_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    check("e4_done", 64'(done), 64'd1);
    check("e4_m_valid", 64'(s_if.m_valid), 64'd0);
    @(posedge clk);
    #1;
    check("e5_done", 64'(done), 64'd0);
    check("e5_busy", 64'(busy), 64'd0);

    for (int t = 0; t < 7; t++) run_job(t, jobs[t]);

    // Reset in the middle of a two-row drain, then a clean restart.
    @(negedge clk);
    base_addr    = AW'(200);
    drain_rows   = RW'(2);
    start        = 1'b1;
    s_if.m_ready = 1'b1;
    push_job(200, 2);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20 && !s_if.m_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("midrst_reached_send", 64'(s_if.m_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("midrst_m_valid", 64'(s_if.m_valid), 64'd0);
    check("midrst_m_data", 64'(s_if.m_data), 64'd0);
    check("midrst_m_last", 64'(s_if.m_last), 64'd0);
    check("midrst_m_frame_last", 64'(s_if.m_frame_last), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid_address", 64'(valid_address), 64'd0);
    check("midrst_sram_address", 64'(sram_result_address), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn   = 1'b1;
    dcount = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) dcount++;
    end
    check("midrst_no_done_after", 64'(dcount), 64'd0);
    run_job(7, jobs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
